multi_vector_writer: RTL

//  Successor to the single-vector result writer. Writes the Dijkstra prev (index) vector and/or

---
 rtl/multi_vector_writer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/multi_vector_writer.sv
// Writes the Dijkstra prev and/or dist vectors to shared BlockRam, one entry per word,
// using a 4-phase handshake; the address/data bus is tri-stated whenever no write is requested.
module multi_vector_writer #(
    parameter int unsigned MAX_NODES   = 8,
    parameter int unsigned INDEX_WIDTH = 4,
    parameter int unsigned VALUE_WIDTH = 8,
    parameter int unsigned MADDR_WIDTH = 12,
    parameter int unsigned MDATA_WIDTH = 16
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             enable,
    input  logic [1:0]                       mode,
    input  logic [MADDR_WIDTH-1:0]           prev_base,
    input  logic [MADDR_WIDTH-1:0]           dist_base,
    input  logic [MAX_NODES*INDEX_WIDTH-1:0] prev_vector,
    input  logic [MAX_NODES*VALUE_WIDTH-1:0] dist_vector,
    input  logic [INDEX_WIDTH-1:0]           number_of_nodes,
    output logic                             mem_write_enable,
    input  logic                             mem_write_ready,
    output logic [MADDR_WIDTH-1:0]           mem_addr,
    output logic [MDATA_WIDTH-1:0]           mem_write_data,
    output logic [INDEX_WIDTH:0]             words_written,
    output logic                             error,
    output logic                             ready
);

    localparam int unsigned STEP = MDATA_WIDTH / 8;
    localparam int unsigned CW   = INDEX_WIDTH + 1;

    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, RELEASE, DONE} state_t;

    state_t                 state;
    logic [1:0]             mode_q;
    logic [MADDR_WIDTH-1:0] prev_base_q;
    logic [MADDR_WIDTH-1:0] dist_base_q;
    logic [INDEX_WIDTH-1:0] n_q;
    logic [CW-1:0]          total_q;

    logic [CW-1:0]          entry_idx;
    logic [CW-1:0]          addr_off;
    logic                   sel_dist;
    logic [MADDR_WIDTH-1:0] word_base;
    logic [MADDR_WIDTH-1:0] word_addr;
    logic [MDATA_WIDTH-1:0] word_data;

    // The acknowledged-write count doubles as the index k of the word being issued.
    always_comb begin
        entry_idx = words_written;
        addr_off  = words_written;
        sel_dist  = 1'b0;
        word_base = prev_base_q;
        case (mode_q)
            2'b01: begin
                sel_dist  = 1'b1;
                word_base = dist_base_q;
            end
            2'b10: begin
                if (words_written >= {1'b0, n_q}) begin
                    sel_dist  = 1'b1;
                    word_base = dist_base_q;
                    entry_idx = words_written - {1'b0, n_q};
                    addr_off  = words_written - {1'b0, n_q};
                end
            end
            2'b11: begin
                sel_dist  = words_written[0];
                entry_idx = words_written >> 1;
            end
            default: ;
        endcase
        word_addr = word_base + MADDR_WIDTH'(addr_off * STEP);
        if (sel_dist)
            word_data = MDATA_WIDTH'(dist_vector[entry_idx*VALUE_WIDTH +: VALUE_WIDTH]);
        else
            word_data = MDATA_WIDTH'(prev_vector[entry_idx*INDEX_WIDTH +: INDEX_WIDTH]);
    end

    assign mem_addr       = mem_write_enable ? word_addr : 'z;
    assign mem_write_data = mem_write_enable ? word_data : 'z;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            mem_write_enable <= 1'b0;
            words_written    <= '0;
            error            <= 1'b0;
            ready            <= 1'b0;
            mode_q           <= '0;
            prev_base_q      <= '0;
            dist_base_q      <= '0;
            n_q              <= '0;
            total_q          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        words_written <= '0;
                        error         <= 1'b0;
                        ready         <= 1'b0;
                        state         <= LOAD;
                    end
                end
                LOAD: begin
                    mode_q      <= mode;
                    prev_base_q <= prev_base;
                    dist_base_q <= dist_base;
                    n_q         <= number_of_nodes;
                    total_q     <= mode[1] ? {number_of_nodes, 1'b0} : {1'b0, number_of_nodes};
                    if ({1'b0, number_of_nodes} > CW'(MAX_NODES)) begin
                        error <= 1'b1;
                        ready <= 1'b1;
                        state <= DONE;
                    end else if (number_of_nodes == '0) begin
                        ready <= 1'b1;
                        state <= DONE;
                    end else begin
                        mem_write_enable <= 1'b1;
                        state            <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_write_ready) begin
                        mem_write_enable <= 1'b0;
                        words_written    <= words_written + 1'b1;
                        state            <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!mem_write_ready) begin
                        if (words_written < total_q) begin
                            mem_write_enable <= 1'b1;
                            state            <= ISSUE;
                        end else begin
                            ready <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (!enable) begin
                        ready <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
